// File: rtl/ttpu_pkg.sv
// ttpu_pkg: shared types and sizing helpers for the image writer slice
package ttpu_pkg;
  typedef enum logic [1:0] {IDLE, LOAD, DRAIN, FINISH} writer_state_t;
  localparam int LANES = 2;
  localparam int ELEM_W = 16;
  typedef logic [LANES-1:0][ELEM_W-1:0] lane_vec_t;
  function automatic int addr_width(input int w, input int h);
    return $clog2(w * h);
  endfunction
endpackage

// File: rtl/image_writer_raster_addr_gen.sv
// raster_addr_gen: row/col counters walking a window and producing its memory address
module raster_addr_gen #(
  parameter int IMAGE_WIDTH = 8,
  parameter int IMAGE_HEIGHT = 8,
  parameter int ADDR_WIDTH = 6,
  parameter int CW = $clog2(IMAGE_WIDTH + 1),
  parameter int RW = $clog2(IMAGE_HEIGHT + 1)
) (
  input  logic                  clk,
  input  logic                  reset,
  input  logic                  clr,
  input  logic                  adv,
  input  logic [ADDR_WIDTH-1:0] base,
  input  logic [CW-1:0]         width,
  output logic [ADDR_WIDTH-1:0] addr,
  output logic                  last_col
);
  logic [CW-1:0] col;
  logic [RW-1:0] row;
  assign last_col = col == width - CW'(1);
  // modulo-2^ADDR_WIDTH arithmetic gives the same result as full-width-then-truncate
  assign addr = base + ADDR_WIDTH'(row) * ADDR_WIDTH'(IMAGE_WIDTH) + ADDR_WIDTH'(col);
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      col <= '0;
      row <= '0;
    end else if (clr) begin
      col <= '0;
      row <= '0;
    end else if (adv) begin
      col <= last_col ? '0 : col + CW'(1);
      row <= last_col ? row + RW'(1) : row;
    end
  end
endmodule

// File: rtl/image_writer.sv
// image_writer: serializes multi-lane result beats into a raster window of the image memory
module image_writer
  import ttpu_pkg::*;
#(
  parameter int DATA_WIDTH = 16,
  parameter int IMAGE_WIDTH = 8,
  parameter int IMAGE_HEIGHT = 8,
  parameter int NUM_UNITS = 2,
  parameter int ADDR_WIDTH = addr_width(IMAGE_WIDTH, IMAGE_HEIGHT)
) (
  input  logic                                 clk,
  input  logic                                 reset,
  input  logic                                 start,
  input  logic [ADDR_WIDTH-1:0]                base_addr,
  input  logic [$clog2(IMAGE_WIDTH+1)-1:0]     out_width,
  input  logic [$clog2(IMAGE_HEIGHT+1)-1:0]    out_height,
  input  logic                                 in_valid,
  output logic                                 in_ready,
  input  logic [NUM_UNITS-1:0][DATA_WIDTH-1:0] in_data,
  output logic                                 wr_en,
  output logic [ADDR_WIDTH-1:0]                wr_addr,
  output logic [DATA_WIDTH-1:0]                wr_data,
  output logic                                 busy,
  output logic                                 done
);
  localparam int CW = $clog2(IMAGE_WIDTH + 1);
  localparam int MW = $clog2(IMAGE_WIDTH * IMAGE_HEIGHT + 1);
  localparam int LW = NUM_UNITS > 1 ? $clog2(NUM_UNITS) : 1;
  writer_state_t state, next;
  logic [NUM_UNITS-1:0][DATA_WIDTH-1:0] lanes;
  logic [LW-1:0] lane;
  logic [MW-1:0] remaining, job_size;
  logic [ADDR_WIDTH-1:0] base_q, addr;
  logic [CW-1:0] width_q;
  logic last_col, clr, drain;
  assign job_size = MW'(out_width) * MW'(out_height);
  assign clr = state == IDLE && start;
  assign drain = state == DRAIN;
  assign in_ready = state == LOAD;
  assign busy = state != IDLE;
  // the last write is still on the port during the first FINISH cycle, so done waits for it
  assign done = state == FINISH && !wr_en;
  raster_addr_gen #(
    .IMAGE_WIDTH(IMAGE_WIDTH),
    .IMAGE_HEIGHT(IMAGE_HEIGHT),
    .ADDR_WIDTH(ADDR_WIDTH)
  ) u_addr (
    .clk(clk),
    .reset(reset),
    .clr(clr),
    .adv(drain),
    .base(base_q),
    .width(width_q),
    .addr(addr),
    .last_col(last_col)
  );
  always_comb begin
    next = state;
    case (state)
      IDLE:    if (start) next = job_size == '0 ? FINISH : LOAD;
      LOAD:    if (in_valid) next = DRAIN;
      DRAIN:   next = remaining == MW'(1) ? FINISH : lane == LW'(NUM_UNITS - 1) ? LOAD : DRAIN;
      default: if (!wr_en) next = IDLE;
    endcase
  end
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state     <= IDLE;
      lanes     <= '0;
      lane      <= '0;
      remaining <= '0;
      base_q    <= '0;
      width_q   <= '0;
      wr_en     <= 1'b0;
      wr_addr   <= '0;
      wr_data   <= '0;
    end else begin
      state <= next;
      wr_en <= drain;
      if (clr) begin
        base_q    <= base_addr;
        width_q   <= out_width;
        remaining <= job_size;
      end
      if (state == LOAD && in_valid) begin
        lanes <= in_data;
        lane  <= '0;
      end
      if (drain) begin
        wr_addr   <= addr;
        wr_data   <= lanes[lane];
        lane      <= lane + LW'(1);
        remaining <= remaining - MW'(1);
      end
    end
  end
endmodule

// File: tb/tb_image_writer.sv
// tb_image_writer: directed scenario checks for image_writer with hand-computed write lists
module tb_image_writer;
  import ttpu_pkg::*;
  logic clk = 0, reset = 0, start = 0, in_valid = 0;
  logic [5:0] base_addr = '0;
  logic [3:0] out_width = '0, out_height = '0;
  lane_vec_t in_data = '0;
  logic in_ready, wr_en, busy, done;
  logic [5:0] wr_addr;
  logic [15:0] wr_data;
  int compared = 0, mismatched = 0, cyc = 0, done_cnt = 0, done_cyc = 0, last_wr = 0;
  logic [5:0] wa[$];
  logic [15:0] wd[$];

  image_writer dut (
    .clk(clk), .reset(reset), .start(start), .base_addr(base_addr),
    .out_width(out_width), .out_height(out_height), .in_valid(in_valid),
    .in_ready(in_ready), .in_data(in_data), .wr_en(wr_en), .wr_addr(wr_addr),
    .wr_data(wr_data), .busy(busy), .done(done)
  );

  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;
  always @(negedge clk) begin
    if (wr_en) begin
      wa.push_back(wr_addr);
      wd.push_back(wr_data);
      last_wr = cyc;
    end
    if (done) begin
      done_cnt++;
      done_cyc = cyc;
    end
  end

  task automatic clear_log;
    wa.delete();
    wd.delete();
    done_cnt = 0;
  endtask

  task automatic start_job(input logic [5:0] b, input logic [3:0] w, input logic [3:0] h);
    @(posedge clk); #1;
    base_addr = b; out_width = w; out_height = h; start = 1;
    @(posedge clk); #1;
    start = 0;
  endtask

  task automatic send_beat(input logic [15:0] d0, input logic [15:0] d1, output logic ok);
    in_data[0] = d0; in_data[1] = d1; in_valid = 1; ok = 0;
    for (int i = 0; i < 20 && !ok; i++) begin
      ok = in_ready;
      @(posedge clk); #1;
    end
    in_valid = 0;
  endtask

  task automatic wait_done(output logic ok);
    for (int i = 0; i < 40 && done_cnt == 0; i++) @(posedge clk);
    #1;
    ok = done_cnt != 0;
  endtask

  task automatic test_reset;
    @(posedge clk); #1;
    compared++;
    if ({in_ready, wr_en, busy, done} !== 4'b0) begin
      mismatched++;
      $display("FAIL reset_ctrl got %b want 0000", {in_ready, wr_en, busy, done});
    end
    compared++;
    if ({wr_addr, wr_data} !== 22'h0) begin
      mismatched++;
      $display("FAIL reset_data got %h/%h want 0/0", wr_addr, wr_data);
    end
    @(negedge clk) reset = 1;
  endtask

  task automatic test_basic;
    logic ok1, ok2, ok3, okd;
    logic [5:0] ea[6] = '{6'd9, 6'd10, 6'd11, 6'd17, 6'd18, 6'd19};
    logic [15:0] ed[6] = '{16'hA00A, 16'hB00B, 16'hC00C, 16'hD00D, 16'hE00E, 16'hF00F};
    clear_log();
    start_job(6'd9, 4'd3, 4'd2);
    send_beat(16'hA00A, 16'hB00B, ok1);
    send_beat(16'hC00C, 16'hD00D, ok2);
    send_beat(16'hE00E, 16'hF00F, ok3);
    wait_done(okd);
    compared++;
    if (!(ok1 && ok2 && ok3 && okd)) begin
      mismatched++;
      $display("FAIL basic_handshake got %b%b%b%b want 1111", ok1, ok2, ok3, okd);
    end
    compared++;
    if (wa.size() != 6) begin
      mismatched++;
      $display("FAIL basic_count got %0d want 6", wa.size());
    end
    for (int i = 0; i < 6; i++) begin
      compared++;
      if (i >= wa.size() || wa[i] !== ea[i] || wd[i] !== ed[i]) begin
        mismatched++;
        $display("FAIL basic_write%0d got %0d:%h want %0d:%h", i,
                 i < wa.size() ? wa[i] : 6'h0, i < wd.size() ? wd[i] : 16'h0, ea[i], ed[i]);
      end
    end
    compared++;
    if (done_cyc != last_wr + 1) begin
      mismatched++;
      $display("FAIL basic_done_timing got cycle %0d want %0d", done_cyc, last_wr + 1);
    end
    compared++;
    if (busy !== 1'b0 || done_cnt != 1) begin
      mismatched++;
      $display("FAIL basic_idle got busy=%b dones=%0d want busy=0 dones=1", busy, done_cnt);
    end
  endtask

  task automatic test_partial;
    logic ok1, ok2, okd;
    logic [15:0] ed[3] = '{16'd1, 16'd2, 16'd3};
    clear_log();
    start_job(6'd0, 4'd3, 4'd1);
    send_beat(16'd1, 16'd2, ok1);
    send_beat(16'd3, 16'd4, ok2);
    wait_done(okd);
    repeat (2) @(posedge clk);
    #1;
    compared++;
    if (!(ok1 && ok2 && okd) || wa.size() != 3) begin
      mismatched++;
      $display("FAIL partial_count got %0d writes ok=%b%b%b want 3 ok=111", wa.size(), ok1, ok2, okd);
    end
    for (int i = 0; i < 3; i++) begin
      compared++;
      if (i >= wa.size() || wa[i] !== 6'(i) || wd[i] !== ed[i]) begin
        mismatched++;
        $display("FAIL partial_write%0d got %0d:%0d want %0d:%0d", i,
                 i < wa.size() ? wa[i] : 6'h0, i < wd.size() ? wd[i] : 16'h0, i, ed[i]);
      end
    end
    compared++;
    if (done_cyc != last_wr + 1 || done_cnt != 1) begin
      mismatched++;
      $display("FAIL partial_done got cycle %0d count %0d want %0d count 1", done_cyc, done_cnt, last_wr + 1);
    end
  endtask

  task automatic test_stall;
    logic ok1, okd;
    clear_log();
    start_job(6'd0, 4'd2, 4'd1);
    for (int i = 0; i < 5; i++) begin
      compared++;
      if ({in_ready, busy, wr_en} !== 3'b110) begin
        mismatched++;
        $display("FAIL stall_cycle%0d got ready/busy/wr=%b want 110", i, {in_ready, busy, wr_en});
      end
      @(posedge clk); #1;
    end
    send_beat(16'd7, 16'd8, ok1);
    wait_done(okd);
    compared++;
    if (!(ok1 && okd) || wa.size() != 2 || wa[0] !== 6'd0 || wd[0] !== 16'd7 || wa[1] !== 6'd1 || wd[1] !== 16'd8) begin
      mismatched++;
      $display("FAIL stall_resume got %0d writes first %0d:%0d want 2 writes 0:7 1:8",
               wa.size(), wa.size() > 0 ? wa[0] : 6'h0, wd.size() > 0 ? wd[0] : 16'h0);
    end
  endtask

  task automatic test_zero;
    clear_log();
    start_job(6'd5, 4'd0, 4'd3);
    compared++;
    if ({done, busy} !== 2'b11) begin
      mismatched++;
      $display("FAIL zero_done got done/busy=%b want 11", {done, busy});
    end
    @(posedge clk); #1;
    compared++;
    if ({done, busy} !== 2'b00 || wa.size() != 0) begin
      mismatched++;
      $display("FAIL zero_after got done/busy=%b writes=%0d want 00 writes=0", {done, busy}, wa.size());
    end
  endtask

  task automatic test_busy_start;
    logic ok1, okd;
    clear_log();
    start_job(6'd9, 4'd2, 4'd1);
    base_addr = 6'd40; start = 1;
    @(posedge clk); #1;
    start = 0;
    send_beat(16'd5, 16'd6, ok1);
    wait_done(okd);
    compared++;
    if (!(ok1 && okd) || wa.size() != 2 || wa[0] !== 6'd9 || wa[1] !== 6'd10 || wd[0] !== 16'd5 || wd[1] !== 16'd6) begin
      mismatched++;
      $display("FAIL busy_start got %0d writes first addr %0d want 2 writes at 9,10",
               wa.size(), wa.size() > 0 ? wa[0] : 6'h0);
    end
  endtask

  task automatic test_wrap;
    logic ok1, ok2, okd;
    logic [5:0] ea[3] = '{6'd62, 6'd63, 6'd0};
    logic [15:0] ed[3] = '{16'h1111, 16'h2222, 16'h3333};
    clear_log();
    start_job(6'd62, 4'd3, 4'd1);
    send_beat(16'h1111, 16'h2222, ok1);
    send_beat(16'h3333, 16'h4444, ok2);
    wait_done(okd);
    compared++;
    if (!(ok1 && ok2 && okd) || wa.size() != 3) begin
      mismatched++;
      $display("FAIL wrap_count got %0d writes want 3", wa.size());
    end
    for (int i = 0; i < 3; i++) begin
      compared++;
      if (i >= wa.size() || wa[i] !== ea[i] || wd[i] !== ed[i]) begin
        mismatched++;
        $display("FAIL wrap_write%0d got %0d:%h want %0d:%h", i,
                 i < wa.size() ? wa[i] : 6'h0, i < wd.size() ? wd[i] : 16'h0, ea[i], ed[i]);
      end
    end
  endtask

  task automatic test_reset_mid;
    logic ok1, ok2, okd;
    clear_log();
    start_job(6'd0, 4'd4, 4'd1);
    send_beat(16'd11, 16'd22, ok1);
    @(posedge clk); #1;
    compared++;
    if (wr_en !== 1'b1 || wr_data !== 16'd11) begin
      mismatched++;
      $display("FAIL mid_lane0 got wr_en=%b data=%0d want 1/11", wr_en, wr_data);
    end
    #2 reset = 0;
    #1;
    compared++;
    if ({in_ready, wr_en, busy, done} !== 4'b0 || {wr_addr, wr_data} !== 22'h0) begin
      mismatched++;
      $display("FAIL mid_reset_outputs got ctrl=%b addr=%0d data=%0d want all 0",
               {in_ready, wr_en, busy, done}, wr_addr, wr_data);
    end
    @(negedge clk) reset = 1;
    repeat (3) @(posedge clk);
    #1;
    compared++;
    if (busy !== 1'b0 || done_cnt != 0) begin
      mismatched++;
      $display("FAIL mid_idle got busy=%b dones=%0d want 0/0", busy, done_cnt);
    end
    clear_log();
    start_job(6'd20, 4'd2, 4'd1);
    send_beat(16'd33, 16'd44, ok2);
    wait_done(okd);
    compared++;
    if (!(ok1 && ok2 && okd) || wa.size() != 2 || wa[0] !== 6'd20 || wa[1] !== 6'd21 || wd[0] !== 16'd33 || wd[1] !== 16'd44) begin
      mismatched++;
      $display("FAIL mid_recover got %0d writes first %0d:%0d want 20:33 21:44",
               wa.size(), wa.size() > 0 ? wa[0] : 6'h0, wd.size() > 0 ? wd[0] : 16'h0);
    end
  endtask

  initial begin
    test_reset();
    test_basic();
    test_partial();
    test_stall();
    test_zero();
    test_busy_start();
    test_wrap();
    test_reset_mid();
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", compared, mismatched);
    $finish;
  end
endmodule

// File: doc/image_writer.md
# image_writer

Write-side counterpart of the windowed image memory. Accepts `NUM_UNITS`-wide result beats from the compute units over a valid/ready stream, serializes them onto the image memory's single write port, and places each element at its raster position inside a rectangular output window (row stride `IMAGE_WIDTH`). It sits between the compute-unit outputs and the memory that the windowed readers later consume.

## Interface

- `DATA_WIDTH`, 16, element width
- `IMAGE_WIDTH`, 8, memory row stride in elements
- `IMAGE_HEIGHT`, 8, memory rows
- `NUM_UNITS`, 2, lanes per input beat
- `ADDR_WIDTH`, `$clog2(IMAGE_WIDTH*IMAGE_HEIGHT)`, derived; do not override

Ports:

- `clk` in 1: single clock, rising edge
- `reset` in 1: asynchronous, active-low (`reset==0` resets)
- `start` in 1: one-cycle pulse; latches job configuration
- `base_addr` in `ADDR_WIDTH`: address of window element (0,0)
- `out_width` in `$clog2(IMAGE_WIDTH+1)`: window columns
- `out_height` in `$clog2(IMAGE_HEIGHT+1)`: window rows
- `in_valid` in 1: input beat valid
- `in_ready` out 1: block accepts a beat
- `in_data` in `[NUM_UNITS][DATA_WIDTH]`: lane 0 is the earliest raster element
- `wr_en` out 1: memory write strobe
- `wr_addr` out `ADDR_WIDTH`: write address
- `wr_data` out `DATA_WIDTH`: write data
- `busy` out 1: job in progress
- `done` out 1: one-cycle pulse after the last write

## Operation

- The FSM has four states: IDLE, LOAD, DRAIN, FINISH.
- **IDLE**
  - `start` latches `base_addr`, `out_width`, `out_height`, clears the counters, and sets `remaining = out_width*out_height`.
  - The next state is LOAD, or FINISH if `remaining==0`.
- **LOAD**
  - `in_ready=1`.
  - On `in_valid&&in_ready`, capture `in_data` into the lane buffer, set `lane=0`, and go to DRAIN.
- **DRAIN**
  - Each cycle writes buffer[`lane`] at `base + row*IMAGE_WIDTH + col`, then increments `col`.
  - At `col==out_width-1`, `col` returns to 0 and `row` increments. Decrement `remaining`.
  - Leave DRAIN after lane `NUM_UNITS-1`, or after the write that makes `remaining==0`, whichever comes first.
  - Remaining lanes of a partial final beat are dropped and never written.
  - The next state is FINISH if `remaining==0`, otherwise LOAD.
- **FINISH**
  - `done=1` for one cycle, then go to IDLE.
- Address arithmetic is computed at full width, then truncated to `ADDR_WIDTH`, so it wraps modulo `2^ADDR_WIDTH`. No bounds error is raised.
- `start` outside IDLE is ignored, and the configuration is not re-latched.
- `in_valid` outside LOAD is ignored. The source holds `in_data` until the handshake completes.
- `busy=1` in LOAD, DRAIN and FINISH.

## Timing

- Reset values: `in_ready=0`, `wr_en=0`, `wr_addr=0`, `wr_data=0`, `busy=0`, `done=0`. State is IDLE and all counters are 0.
- `wr_en`, `wr_addr` and `wr_data` are registered.
- For a beat accepted at edge T, lane i is presented on the write port from edge T+1+i.
- `in_ready` rises 1 cycle after `start` and falls the cycle after acceptance.
- A full beat occupies NUM_UNITS+1 cycles: 1 LOAD cycle plus NUM_UNITS DRAIN cycles.
- `done` is asserted in the cycle after the last `wr_en`.
- A zero-size job (`out_width==0` or `out_height==0`) produces `done` 1 cycle after `start` with no writes.
- If reset asserts mid-job, all outputs clear asynchronously. The partially written window is left as-is, and no `done` is produced.

## Structure

- Shared package `ttpu_pkg`:
  - state enum `writer_state_t` (IDLE, LOAD, DRAIN, FINISH)
  - a `lane_vec_t` packed-array typedef
  - `ADDR_WIDTH` helper function
- Sub-module `raster_addr_gen` holds the `row`/`col` counters, column wrap and address computation.
  - Control inputs: `clr`, `adv`.
  - Outputs: `addr`, `last_col`.
- The top level holds the FSM, lane buffer, `remaining` counter and output registers.

## Test plan

All scenarios use NUM_UNITS=2 and IMAGE_WIDTH=8.

- Basic window: `base_addr=9`, 3×2 window, 3 beats {a,b},{c,d},{e,f} → writes (9,a),(10,b),(11,c),(17,d),(18,e),(19,f). `done` is asserted 1 cycle after the last write.
- Partial last beat: 3×1 window at base 0, beats {1,2},{3,4} → writes 0←1, 1←2, 2←3. Value 4 is never written. `done` follows.
- Backpressure/stall: `in_valid` low for 5 cycles in LOAD → `in_ready` stays 1, no `wr_en`, `busy` stays 1. The job resumes correctly.
- Zero size and busy `start`:
  - `out_width=0` → `done` on the cycle after `start`, no `wr_en`.
  - A second `start` mid-job with a different `base_addr` is ignored; addresses follow the first job.
- Wrap: `base_addr=62`, 3×1 window → writes to addresses 62, 63, 0.
- Reset mid-DRAIN: pull `reset` low between lane 0 and lane 1 → all outputs 0 immediately. After release the block is IDLE, and a new job writes correctly.
